// File: rtl/data_offload_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : data_offload_sync_ctrl
//  Purpose  : Per-channel playback sequencer for the data offload read path.
//             Each of NUM_CH channels arms when its storage buffer is filled,
//             waits for its selected trigger (none / hardware / software /
//             hardware-or-software) and then replays the buffer as a stream
//             of read beats. Replay can be oneshot or cyclic. Each channel
//             counts the syncs that arrive while it is already playing.
//  Ports    : clk, resetn              - clock, async active-low reset
//             sync_ext                 - shared asynchronous hardware sync
//             sync_sw[NUM_CH]          - per-channel software sync pulse
//             ctrl_enable/oneshot      - per-channel enable and replay mode
//             ctrl_sync_mode[2*NUM_CH] - per-channel trigger select
//             ctrl_length              - per-channel beats minus one
//             wr_done[NUM_CH]          - storage filled pulse
//             rd_valid/ready/addr/last - per-channel read beat handshake
//             status_state/miss        - FSM state and missed-sync counter
//  Revision : 1.0 - initial release
// ============================================================================
module data_offload_sync_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int LEN_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MISS_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          sync_ext,
    input  logic [NUM_CH-1:0]             sync_sw,
    input  logic [NUM_CH-1:0]             ctrl_enable,
    input  logic [NUM_CH-1:0]             ctrl_oneshot,
    input  logic [2*NUM_CH-1:0]           ctrl_sync_mode,
    input  logic [NUM_CH*LEN_WIDTH-1:0]   ctrl_length,
    input  logic [NUM_CH-1:0]             wr_done,
    output logic [NUM_CH-1:0]             rd_valid,
    input  logic [NUM_CH-1:0]             rd_ready,
    output logic [NUM_CH*LEN_WIDTH-1:0]   rd_addr,
    output logic [NUM_CH-1:0]             rd_last,
    output logic [2*NUM_CH-1:0]           status_state,
    output logic [NUM_CH*MISS_WIDTH-1:0]  status_miss
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]            C_MODE_NONE = 2'd0;
    localparam logic [1:0]            C_MODE_HW   = 2'd1;
    localparam logic [1:0]            C_MODE_SW   = 2'd2;
    localparam logic [LEN_WIDTH-1:0]  C_ADDR_ONE  = LEN_WIDTH'(1);
    localparam logic [MISS_WIDTH-1:0] C_MISS_ONE  = MISS_WIDTH'(1);
    localparam logic [MISS_WIDTH-1:0] C_MISS_MAX  = '1;

    // ------------------------------------------------------------------------
    // Shared hardware sync: metastability chain followed by a registered
    // rising-edge detector, so a held level yields a single one-cycle event.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   r_hw_evt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
            r_hw_evt    <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], sync_ext};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
            r_hw_evt    <= r_sync[SYNC_STAGES-1] & ~r_sync_prev;
        end
    end

    // ------------------------------------------------------------------------
    // Independent channel sequencers
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t                r_state;
        state_t                w_state_nxt;
        logic [LEN_WIDTH-1:0]  r_addr;
        logic [LEN_WIDTH-1:0]  w_addr_nxt;
        logic [LEN_WIDTH-1:0]  r_len;
        logic [LEN_WIDTH-1:0]  w_len_nxt;
        logic [MISS_WIDTH-1:0] r_miss;
        logic [MISS_WIDTH-1:0] w_miss_nxt;
        logic [1:0]            w_mode;
        logic [LEN_WIDTH-1:0]  w_len_in;
        logic                  w_evt;
        logic                  w_last;
        logic                  w_accept;

        assign w_mode   = ctrl_sync_mode[2*i +: 2];
        assign w_len_in = ctrl_length[i*LEN_WIDTH +: LEN_WIDTH];
        assign w_last   = (r_addr == r_len);
        assign w_accept = (r_state == ST_PLAY) && rd_ready[i];

        // Mode 3 ORs both sources, so coincident syncs form one event.
        always_comb begin
            w_evt = 1'b0;
            case (w_mode)
                C_MODE_NONE: w_evt = 1'b0;
                C_MODE_HW:   w_evt = r_hw_evt;
                C_MODE_SW:   w_evt = sync_sw[i];
                default:     w_evt = r_hw_evt | sync_sw[i];
            endcase
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_state <= ST_IDLE;
                r_addr  <= '0;
                r_len   <= '0;
                r_miss  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_addr  <= w_addr_nxt;
                r_len   <= w_len_nxt;
                r_miss  <= w_miss_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_addr_nxt  = r_addr;
            w_len_nxt   = r_len;
            w_miss_nxt  = r_miss;

            if (!ctrl_enable[i]) begin
                // Disable wins from any state, including mid-burst.
                w_state_nxt = ST_IDLE;
                w_addr_nxt  = '0;
                w_miss_nxt  = '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (wr_done[i]) begin
                            w_state_nxt = ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if ((w_mode == C_MODE_NONE) || w_evt) begin
                            w_state_nxt = ST_PLAY;
                            w_addr_nxt  = '0;
                            // Length is frozen for the whole replay.
                            w_len_nxt   = w_len_in;
                        end
                    end
                    ST_PLAY: begin
                        if (w_evt && (r_miss != C_MISS_MAX)) begin
                            w_miss_nxt = r_miss + C_MISS_ONE;
                        end
                        if (w_accept) begin
                            if (w_last) begin
                                w_addr_nxt = '0;
                                if (ctrl_oneshot[i]) begin
                                    w_state_nxt = ST_DONE;
                                end else if (w_mode != C_MODE_NONE) begin
                                    w_state_nxt = ST_ARMED;
                                end
                                // Free-running cyclic replay wraps in place.
                            end else begin
                                w_addr_nxt = r_addr + C_ADDR_ONE;
                            end
                        end
                    end
                    default: begin
                        if (wr_done[i]) begin
                            w_state_nxt = ST_ARMED;
                        end
                    end
                endcase
            end
        end

        assign rd_valid[i]                            = (r_state == ST_PLAY);
        assign rd_last[i]                             = (r_state == ST_PLAY) && w_last;
        assign rd_addr[i*LEN_WIDTH +: LEN_WIDTH]      = r_addr;
        assign status_state[2*i +: 2]                 = r_state;
        assign status_miss[i*MISS_WIDTH +: MISS_WIDTH] = r_miss;
    end

endmodule
`default_nettype wire

// File: tb/tb_data_offload_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_offload_sync_ctrl
//  Purpose  : Self-checking bench for data_offload_sync_ctrl. Expected beat
//             addresses come from counting accepted beats modulo the
//             transfer length; expected states come from the scenario.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_offload_sync_ctrl;

    localparam int NUM_CH = 4;
    localparam int LW     = 16;
    localparam int SS     = 2;
    localparam int MW     = 8;

    localparam int E_IDLE  = 0;
    localparam int E_ARMED = 1;
    localparam int E_PLAY  = 2;
    localparam int E_DONE  = 3;

    logic                  clk;
    logic                  resetn;
    logic                  sync_ext;
    logic [NUM_CH-1:0]     sync_sw;
    logic [NUM_CH-1:0]     ctrl_enable;
    logic [NUM_CH-1:0]     ctrl_oneshot;
    logic [2*NUM_CH-1:0]   ctrl_sync_mode;
    logic [NUM_CH*LW-1:0]  ctrl_length;
    logic [NUM_CH-1:0]     wr_done;
    logic [NUM_CH-1:0]     rd_valid;
    logic [NUM_CH-1:0]     rd_ready;
    logic [NUM_CH*LW-1:0]  rd_addr;
    logic [NUM_CH-1:0]     rd_last;
    logic [2*NUM_CH-1:0]   status_state;
    logic [NUM_CH*MW-1:0]  status_miss;

    int n_tests = 0;
    int n_fail  = 0;

    data_offload_sync_ctrl #(
        .NUM_CH(NUM_CH), .LEN_WIDTH(LW), .SYNC_STAGES(SS), .MISS_WIDTH(MW)
    ) dut (
        .clk(clk), .resetn(resetn), .sync_ext(sync_ext), .sync_sw(sync_sw),
        .ctrl_enable(ctrl_enable), .ctrl_oneshot(ctrl_oneshot),
        .ctrl_sync_mode(ctrl_sync_mode), .ctrl_length(ctrl_length),
        .wr_done(wr_done), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_addr(rd_addr), .rd_last(rd_last), .status_state(status_state),
        .status_miss(status_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int addr_of(input int ch);
        return int'(rd_addr[ch*LW +: LW]);
    endfunction
    function automatic int st_of(input int ch);
        return int'(status_state[2*ch +: 2]);
    endfunction
    function automatic int miss_of(input int ch);
        return int'(status_miss[ch*MW +: MW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sync_ext       = 1'b0;
        sync_sw        = '0;
        ctrl_enable    = '0;
        ctrl_oneshot   = '0;
        ctrl_sync_mode = '0;
        ctrl_length    = '0;
        wr_done        = '0;
        rd_ready       = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic cfg(input int ch, input int en, input int os, input int mode, input int len);
        ctrl_enable[ch]           = en[0];
        ctrl_oneshot[ch]          = os[0];
        ctrl_sync_mode[2*ch +: 2] = mode[1:0];
        ctrl_length[ch*LW +: LW]  = len[LW-1:0];
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        resetn = 1'b1;
        #2;
        resetn = 1'b0;
        tick();
        tick();
        n_tests++; if (rd_valid !== '0) begin n_fail++; $display("FAIL reset_valid: got %h expected 0", rd_valid); end
        n_tests++; if (rd_last !== '0) begin n_fail++; $display("FAIL reset_last: got %h expected 0", rd_last); end
        n_tests++; if (rd_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", rd_addr); end
        n_tests++; if (status_state !== '0) begin n_fail++; $display("FAIL reset_state: got %h expected 0", status_state); end
        n_tests++; if (status_miss !== '0) begin n_fail++; $display("FAIL reset_miss: got %h expected 0", status_miss); end
        resetn = 1'b1;
        ctrl_enable = '1;
        tick();
        tick();
        n_tests++; if (status_state !== '0) begin n_fail++; $display("FAIL idle_without_wr_done: got %h expected 0", status_state); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_hw_oneshot();
        int acc;
        int cyc;
        int r;
        do_reset();
        cfg(0, 1, 1, 1, 7);
        wr_done[0] = 1'b1; tick(); wr_done[0] = 1'b0;
        n_tests++; if (st_of(0) !== E_ARMED) begin n_fail++; $display("FAIL hw1_armed: got %0d expected %0d", st_of(0), E_ARMED); end
        sync_ext = 1'b1;
        for (int i = 0; i < SS + 1; i++) begin
            tick();
            n_tests++; if (rd_valid[0] !== 1'b0) begin n_fail++; $display("FAIL hw1_early_valid: edge %0d got %b expected 0", i + 1, rd_valid[0]); end
        end
        tick();
        n_tests++; if (rd_valid[0] !== 1'b1) begin n_fail++; $display("FAIL hw1_latency: got %b expected 1", rd_valid[0]); end
        acc = 0;
        cyc = 0;
        while (acc < 8 && cyc < 200) begin
            n_tests++;
            if (rd_valid[0] !== 1'b1 || addr_of(0) !== acc || rd_last[0] !== (acc == 7)) begin
                n_fail++;
                $display("FAIL hw1_beat: valid=%b addr=%0d last=%b expected valid=1 addr=%0d last=%b",
                         rd_valid[0], addr_of(0), rd_last[0], 1'b1, acc, (acc == 7));
            end
            r = $urandom_range(0, 1);
            rd_ready[0] = r[0];
            tick();
            if (r != 0) acc++;
            cyc++;
        end
        rd_ready[0] = 1'b0;
        n_tests++; if (acc !== 8) begin n_fail++; $display("FAIL hw1_beat_count: got %0d expected 8", acc); end
        n_tests++; if (st_of(0) !== E_DONE || rd_valid[0] !== 1'b0) begin n_fail++; $display("FAIL hw1_done: state=%0d valid=%b expected state=%0d valid=0", st_of(0), rd_valid[0], E_DONE); end
        sync_ext = 1'b0;
        repeat (4) tick();
        sync_ext = 1'b1;
        repeat (8) tick();
        n_tests++; if (st_of(0) !== E_DONE || rd_valid[0] !== 1'b0 || miss_of(0) !== 0) begin n_fail++; $display("FAIL hw1_second_sync: state=%0d valid=%b miss=%0d expected %0d 0 0", st_of(0), rd_valid[0], miss_of(0), E_DONE); end
        sync_ext = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_cyclic_free();
        int acc;
        int a;
        do_reset();
        cfg(1, 1, 0, 0, 3);
        wr_done[1] = 1'b1; tick(); wr_done[1] = 1'b0;
        tick();
        acc = 0;
        for (int c = 0; c < 24; c++) begin
            a = acc % 4;
            n_tests++;
            if (rd_valid[1] !== 1'b1 || addr_of(1) !== a || rd_last[1] !== (a == 3)) begin
                n_fail++;
                $display("FAIL cyc0_beat: cycle %0d valid=%b addr=%0d last=%b expected valid=1 addr=%0d last=%b",
                         c, rd_valid[1], addr_of(1), rd_last[1], a, (a == 3));
            end
            rd_ready[1] = (c % 2 == 0);
            tick();
            if (c % 2 == 0) acc++;
        end
        n_tests++; if (acc !== 12) begin n_fail++; $display("FAIL cyc0_accepts: got %0d expected 12", acc); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_hw_cyclic_miss();
        int cyc;
        do_reset();
        cfg(2, 1, 0, 1, 15);
        rd_ready[2] = 1'b1;
        wr_done[2] = 1'b1; tick(); wr_done[2] = 1'b0;
        n_tests++; if (st_of(2) !== E_ARMED) begin n_fail++; $display("FAIL hwc_armed: got %0d expected %0d", st_of(2), E_ARMED); end
        sync_ext = 1'b1; tick(); tick(); sync_ext = 1'b0;
        cyc = 0;
        while (rd_valid[2] !== 1'b1 && cyc < 10) begin tick(); cyc++; end
        n_tests++; if (rd_valid[2] !== 1'b1) begin n_fail++; $display("FAIL hwc_start1: valid=%b expected 1 within 10 cycles", rd_valid[2]); end
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (addr_of(2) !== i || rd_valid[2] !== 1'b1) begin n_fail++; $display("FAIL hwc_beat: addr=%0d valid=%b expected addr=%0d valid=1", addr_of(2), rd_valid[2], i); end
            if (i == 2) sync_ext = 1'b1;
            if (i == 4) sync_ext = 1'b0;
            tick();
        end
        n_tests++; if (st_of(2) !== E_ARMED || rd_valid[2] !== 1'b0) begin n_fail++; $display("FAIL hwc_rearm: state=%0d valid=%b expected %0d 0", st_of(2), rd_valid[2], E_ARMED); end
        repeat (8) tick();
        n_tests++; if (st_of(2) !== E_ARMED) begin n_fail++; $display("FAIL hwc_no_replay_on_miss: got %0d expected %0d", st_of(2), E_ARMED); end
        n_tests++; if (miss_of(2) !== 1) begin n_fail++; $display("FAIL hwc_miss: got %0d expected 1", miss_of(2)); end
        sync_ext = 1'b1; tick(); tick(); sync_ext = 1'b0;
        cyc = 0;
        while (rd_valid[2] !== 1'b1 && cyc < 10) begin tick(); cyc++; end
        n_tests++; if (rd_valid[2] !== 1'b1 || addr_of(2) !== 0) begin n_fail++; $display("FAIL hwc_start2: valid=%b addr=%0d expected 1 0", rd_valid[2], addr_of(2)); end
        n_tests++; if (miss_of(2) !== 1) begin n_fail++; $display("FAIL hwc_miss_hold: got %0d expected 1", miss_of(2)); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_mode3_two_ch();
        int beats;
        do_reset();
        cfg(0, 1, 1, 3, 40);
        cfg(1, 1, 1, 2, 5);
        rd_ready[1:0] = 2'b11;
        wr_done[1:0] = 2'b11; tick(); wr_done = '0;
        sync_ext = 1'b1;
        repeat (SS + 1) tick();
        sync_sw[0] = 1'b1; tick(); sync_sw[0] = 1'b0;
        n_tests++; if (st_of(0) !== E_PLAY || rd_valid[0] !== 1'b1) begin n_fail++; $display("FAIL m3_start: state=%0d valid=%b expected %0d 1", st_of(0), rd_valid[0], E_PLAY); end
        n_tests++; if (st_of(1) !== E_ARMED || rd_valid[1] !== 1'b0) begin n_fail++; $display("FAIL m3_ch1_idle: state=%0d valid=%b expected %0d 0", st_of(1), rd_valid[1], E_ARMED); end
        beats = 0;
        for (int c = 0; c < 80; c++) begin
            if (rd_valid[0] === 1'b1) beats++;
            if (c == 0) sync_ext = 1'b0;
            if (c == 3) sync_ext = 1'b1;
            sync_sw[0] = (c == 3 + SS + 1);
            tick();
        end
        sync_sw[0] = 1'b0;
        sync_ext   = 1'b0;
        n_tests++; if (beats !== 41) begin n_fail++; $display("FAIL m3_beats_once: got %0d expected 41", beats); end
        n_tests++; if (st_of(0) !== E_DONE) begin n_fail++; $display("FAIL m3_done: got %0d expected %0d", st_of(0), E_DONE); end
        n_tests++; if (miss_of(0) !== 1) begin n_fail++; $display("FAIL m3_coincident_miss: got %0d expected 1", miss_of(0)); end
        n_tests++; if (st_of(1) !== E_ARMED || miss_of(1) !== 0) begin n_fail++; $display("FAIL m3_ch1_final: state=%0d miss=%0d expected %0d 0", st_of(1), miss_of(1), E_ARMED); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_abort_reset();
        int cyc;
        int r;
        do_reset();
        cfg(3, 1, 1, 2, 10);
        wr_done[3] = 1'b1; tick(); wr_done[3] = 1'b0;
        sync_sw[3] = 1'b1; tick();
        tick(); sync_sw[3] = 1'b0;
        cyc = 0;
        while (addr_of(3) != 5 && cyc < 100) begin
            r = $urandom_range(0, 1);
            rd_ready[3] = r[0];
            tick();
            cyc++;
        end
        rd_ready[3] = 1'b0;
        n_tests++; if (addr_of(3) !== 5 || rd_valid[3] !== 1'b1) begin n_fail++; $display("FAIL abort_reach5: addr=%0d valid=%b expected 5 1", addr_of(3), rd_valid[3]); end
        n_tests++; if (miss_of(3) !== 1) begin n_fail++; $display("FAIL abort_pre_miss: got %0d expected 1", miss_of(3)); end
        ctrl_enable[3] = 1'b0;
        tick();
        n_tests++;
        if (st_of(3) !== E_IDLE || rd_valid[3] !== 1'b0 || addr_of(3) !== 0 || miss_of(3) !== 0 || rd_last[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: state=%0d valid=%b addr=%0d miss=%0d last=%b expected 0 0 0 0 0",
                     st_of(3), rd_valid[3], addr_of(3), miss_of(3), rd_last[3]);
        end
        ctrl_enable[3] = 1'b1;
        wr_done[3] = 1'b1; tick(); wr_done[3] = 1'b0;
        sync_sw[3] = 1'b1; tick(); sync_sw[3] = 1'b0;
        rd_ready[3] = 1'b1;
        repeat (3) tick();
        n_tests++; if (addr_of(3) !== 3 || rd_valid[3] !== 1'b1) begin n_fail++; $display("FAIL rst_pre: addr=%0d valid=%b expected 3 1", addr_of(3), rd_valid[3]); end
        #2;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (rd_valid !== '0 || rd_addr !== '0 || status_state !== '0 || status_miss !== '0 || rd_last !== '0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%h addr=%h state=%h miss=%h last=%h expected all 0",
                     rd_valid, rd_addr, status_state, status_miss, rd_last);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_miss_sat();
        int r;
        do_reset();
        cfg(0, 1, 1, 2, 1000);
        wr_done[0] = 1'b1; tick(); wr_done[0] = 1'b0;
        sync_sw[0] = 1'b1; tick(); sync_sw[0] = 1'b0;
        for (int p = 0; p < 300; p++) begin
            sync_sw[0] = 1'b1;
            tick();
            sync_sw[0] = 1'b0;
            r = $urandom_range(0, 1);
            if (r != 0) tick();
            if (p == 253) begin
                n_tests++; if (miss_of(0) !== 254) begin n_fail++; $display("FAIL sat_254: got %0d expected 254", miss_of(0)); end
            end
        end
        tick();
        n_tests++; if (miss_of(0) !== 255) begin n_fail++; $display("FAIL sat_255: got %0d expected 255", miss_of(0)); end
        n_tests++; if (rd_valid[0] !== 1'b1 || addr_of(0) !== 0) begin n_fail++; $display("FAIL sat_hold_beat: valid=%b addr=%0d expected 1 0", rd_valid[0], addr_of(0)); end
    endtask

    // ------------------------------------------------------------------------
    // All channels free-running cyclic with random lengths (channel 0 uses a
    // single-beat transfer) and random ready. Mid-run length changes and
    // wr_done pulses must not disturb the replay.
    task automatic test_random_cyclic();
        int len [NUM_CH];
        int acc [NUM_CH];
        int a;
        int r;
        int nl;
        do_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            len[ch] = (ch == 0) ? 0 : $urandom_range(1, 9);
            acc[ch] = 0;
            cfg(ch, 1, 0, 0, len[ch]);
        end
        wr_done = '1; tick(); wr_done = '0;
        tick();
        for (int c = 0; c < 200; c++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                a = acc[ch] % (len[ch] + 1);
                n_tests++;
                if (rd_valid[ch] !== 1'b1 || addr_of(ch) !== a || rd_last[ch] !== (a == len[ch])) begin
                    n_fail++;
                    $display("FAIL rnd_beat: ch%0d cycle %0d valid=%b addr=%0d last=%b expected valid=1 addr=%0d last=%b",
                             ch, c, rd_valid[ch], addr_of(ch), rd_last[ch], a, (a == len[ch]));
                end
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r = $urandom_range(0, 1);
                rd_ready[ch] = r[0];
                if (c == 50) begin
                    nl = $urandom_range(0, 20);
                    ctrl_length[ch*LW +: LW] = nl[LW-1:0];
                end
            end
            wr_done = (c == 100) ? '1 : '0;
            tick();
            for (int ch = 0; ch < NUM_CH; ch++) if (rd_ready[ch]) acc[ch]++;
        end
        wr_done  = '0;
        rd_ready = '0;
    endtask

    initial begin
        resetn = 1'b1;
        clear_inputs();
        test_reset();
        test_hw_oneshot();
        test_cyclic_free();
        test_hw_cyclic_miss();
        test_mode3_two_ch();
        test_abort_reset();
        test_miss_sat();
        test_random_cyclic();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
